// File: rtl/key_event_ctrl.sv
// Key event controller: queues debounced key codes in a FIFO and hands them to a CPU
// over an asynchronous SRAM-style read bus, one pop per completed bus read.
module key_event_ctrl #(
    parameter int B     = 3,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B:0]   key_code,
    input  logic         key_valid,
    input  logic         ncs,
    input  logic         noe,
    inout  wire  [B:0]   sram_data,
    output logic         irq,
    output logic         led
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_POP} rd_state_t;

    rd_state_t       r_state, w_state_nxt;
    logic [B:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count, w_cnt_nxt;
    logic            r_ovf, r_irq;
    logic [B:0]      r_rd_reg;
    logic [1:0]      r_ncs_s, r_noe_s;
    logic            w_rd_act, w_full, w_nonzero, w_pop, w_push, w_drop;

    // Bus strobes are asynchronous to clk; idle value is 1 so reset looks like no read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ncs_s <= 2'b11;
            r_noe_s <= 2'b11;
        end else begin
            r_ncs_s <= {r_ncs_s[0], ncs};
            r_noe_s <= {r_noe_s[0], noe};
        end
    end

    assign w_rd_act  = ~r_ncs_s[1] & ~r_noe_s[1];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_nonzero = |key_code;
    assign w_pop     = (r_state == R_POP) && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = key_valid && w_nonzero && (!w_full || w_pop);
    assign w_drop    = key_valid && w_nonzero && w_full && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            R_IDLE:   if (w_rd_act)  w_state_nxt = R_ACTIVE;
            R_ACTIVE: if (!w_rd_act) w_state_nxt = R_POP;
            R_POP:                   w_state_nxt = R_IDLE;
            default:                 w_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + 1'b1;
            2'b01:   w_cnt_nxt = r_count - 1'b1;
            default: w_cnt_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= key_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= R_IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_rd_reg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_cnt_nxt;
            r_irq   <= (r_count != '0);
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_pop && w_cnt_nxt == '0)
                r_ovf <= 1'b0;
            // Track the head while idle; hold it steady for the whole bus read.
            if (r_state == R_IDLE)
                r_rd_reg <= (r_count != '0) ? r_mem[r_rptr] : '0;
        end
    end

    assign sram_data = (!ncs && !noe) ? r_rd_reg : 'z;
    assign irq       = r_irq;
    assign led       = r_ovf;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random push/read traffic
// checked against a queue-based model of the key FIFO.
module tb_key_event_ctrl;
    localparam int B     = 3;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [B:0]   key_code;
    logic         key_valid;
    logic         ncs, noe;
    wire  [B:0]   sram_data;
    logic         irq, led;

    key_event_ctrl #(.B(B), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .ncs(ncs), .noe(noe), .sram_data(sram_data), .irq(irq), .led(led)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [B:0]  q[$];
    bit          m_ovf = 1'b0;
    logic [31:0] zval;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_irq"}, {31'b0, irq}, {31'b0, q.size() != 0});
        chk({tag, "_led"}, {31'b0, led}, {31'b0, m_ovf});
    endtask

    // Strobe one key; the status is checked one edge after the push edge.
    task automatic push(input logic [B:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        if (code != 0) begin
            if (q.size() < DEPTH) q.push_back(code);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
        @(posedge clk);
        @(negedge clk);
        chk_status("push");
    endtask

    // Full bus read; pop_code != 0 strobes a key during the R_POP cycle.
    task automatic cpu_read(input int hold, input logic [B:0] pop_code);
        logic [31:0] exp;
        bit          full_before, popped;
        exp = (q.size() != 0) ? {28'b0, q[0]} : 32'b0;
        @(negedge clk);
        ncs = 1'b0;
        noe = 1'b0;
        repeat (hold) @(negedge clk);
        chk("rd_data", {28'b0, sram_data}, exp);
        ncs = 1'b1;
        noe = 1'b1;
        repeat (3) @(posedge clk);
        if (pop_code != 0) begin
            @(negedge clk);
            key_valid = 1'b1;
            key_code  = pop_code;
        end
        @(posedge clk);
        full_before = (q.size() == DEPTH);
        popped      = (q.size() != 0);
        if (popped) void'(q.pop_front());
        if (pop_code != 0) begin
            if (!full_before || popped) q.push_back(pop_code);
            else m_ovf = 1'b1;
        end
        if (popped && q.size() == 0) m_ovf = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_status("read");
    endtask

    initial begin
        zval      = {28'b0, 4'bzzzz};
        reset     = 1'b0;
        ncs       = 1'b1;
        noe       = 1'b1;
        key_valid = 1'b0;
        key_code  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_irq", {31'b0, irq}, 32'b0);
        chk("rst_led", {31'b0, led}, 32'b0);
        chk("rst_bus_z", {28'b0, sram_data}, zval);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single key
        push(4'd5);
        cpu_read(5, '0);

        // ordering and pointer wrap
        for (int i = 1; i <= 8; i++) push(4'(i));
        for (int i = 0; i < 4; i++) cpu_read(4, '0);
        for (int i = 9; i <= 12; i++) push(4'(i));
        for (int i = 0; i < 8; i++) cpu_read(6, '0);

        // overflow: ninth key dropped, led clears on the emptying read
        for (int i = 1; i <= 9; i++) push(4'(i));
        for (int i = 0; i < 8; i++) cpu_read(4, '0);

        // push accepted on the R_POP cycle of a full FIFO; next push overflows
        for (int i = 1; i <= 8; i++) push(4'(i));
        cpu_read(4, 4'd9);
        push(4'd10);
        for (int i = 0; i < 8; i++) cpu_read(4, '0);

        // empty read and zero code
        cpu_read(5, '0);
        push(4'd0);
        push(4'd3);
        cpu_read(4, '0);

        // reset in the middle of a read; read continues as a fresh one after release
        push(4'd3); push(4'd4); push(4'd5);
        @(negedge clk);
        ncs = 1'b0;
        noe = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_irq", {31'b0, irq}, 32'b0);
        chk("mid_rst_led", {31'b0, led}, 32'b0);
        chk("mid_rst_data", {28'b0, sram_data}, 32'b0);
        q.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_data", {28'b0, sram_data}, 32'b0);
        ncs = 1'b1;
        #1;
        chk("post_rst_bus_z", {28'b0, sram_data}, zval);
        noe = 1'b1;
        repeat (6) @(negedge clk);
        chk_status("post_rst");
        push(4'd7);
        cpu_read(4, '0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) < 2)
                push(4'($urandom_range(0, 15)));
            else
                cpu_read(int'($urandom_range(4, 8)),
                         ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
        end
        while (q.size() != 0) cpu_read(4, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
